div_unit_radix: RTL and testbench

- Parametrised iterative integer divider for the execute stage. Serves RV32M/RV64M DIV, DIVU, REM and REMU.
- Successor of the fixed single-bit divider. Adds:
  - configurable XLEN and radix (bits retired per cycle);
  - single-cycle kill;
  - registered special-case handling for divide-by-zero and signed overflow.
- Sits beside the ALU. The execute stage drives enable, holds its operands stable while ready=0, and stalls on ready=0.

---
 rtl/div_unit_radix.sv | 209 ++++++++++++++++++++
 tb/tb_div_unit_radix.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_radix.sv
// rtl/div_unit_radix.sv - Iterative radix-2^BPC integer divider for RV32M/RV64M DIV/DIVU/REM/REMU
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   enable  request; held high for the life of one division, low kills it
//   div_op  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rdata1  dividend (sampled only at the capture edge)
//   rdata2  divisor  (sampled only at the capture edge)
//   ready   registered one-cycle pulse marking result valid
//   result  quotient or remainder; holds until the next completed division
//
// Parameters: XLEN (32 or 64), BPC quotient bits per cycle (1, 2 or 4).
// Optional: define DIV_EARLY_OUT_EN to skip iteration when |dividend| < |divisor|.

module div_unit_radix #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]      op;
    logic            sign_a;
    logic            sign_b;
    logic            spec_zero;
    logic            spec_ovf;
    logic [XLEN-1:0] quo;       // dividend shifts out at the MSB, quotient bits enter at the LSB
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   rem;       // extra bit covers the shifted partial remainder
    logic [CW-1:0]   counter;

    // Capture-edge decode of the incoming operands
    logic            in_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            in_zero;
    logic            in_ovf;
    logic            in_early;

    assign in_signed = ~div_op[0];
    assign abs_a     = (in_signed && rdata1[XLEN-1]) ? -rdata1 : rdata1;
    assign abs_b     = (in_signed && rdata2[XLEN-1]) ? -rdata2 : rdata2;
    assign in_zero   = (rdata2 == '0);
    assign in_ovf    = in_signed && (rdata1 == MIN_VAL) && (rdata2 == '1);

`ifdef DIV_EARLY_OUT_EN
    // A zero divisor can never satisfy the compare, so no extra guard is needed
    assign in_early = (abs_a < abs_b);
`else
    assign in_early = 1'b0;
`endif

    // BPC restoring steps chained combinationally
    logic [XLEN-1:0] step_q;
    logic [XLEN:0]   step_r;
    logic [XLEN+1:0] trial;

    always_comb begin
        step_q = quo;
        step_r = rem;
        trial  = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {step_r, step_q[XLEN-1]} - {2'b00, dvs};
            if (!trial[XLEN+1]) begin
                step_r = trial[XLEN:0];
            end else begin
                step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
            end
            step_q = {step_q[XLEN-2:0], ~trial[XLEN+1]};
        end
    end

    // Sign fixing and special-case selection for the FIX cycle
    logic            q_neg;
    logic            r_neg;
    logic [XLEN-1:0] q_fixed;
    logic [XLEN-1:0] r_fixed;
    logic [XLEN-1:0] q_sel;
    logic [XLEN-1:0] r_sel;
    logic [XLEN-1:0] fix_val;

    assign q_neg   = ~op[0] & (sign_a ^ sign_b);
    assign r_neg   = ~op[0] & sign_a;
    assign q_fixed = q_neg ? -quo : quo;
    assign r_fixed = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    always_comb begin
        q_sel = q_fixed;
        r_sel = r_fixed;
        if (spec_ovf) begin
            q_sel = MIN_VAL;
            r_sel = '0;
        end else if (spec_zero) begin
            // rem was loaded with |dividend|, so sign fixing restores rdata1 exactly
            q_sel = '1;
        end
        fix_val = op[1] ? r_sel : q_sel;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (in_zero || in_ovf || in_early) begin
                        state_nxt = FIX;
                    end else begin
                        state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (counter == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = enable ? DONE : IDLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op        <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            spec_zero <= 1'b0;
            spec_ovf  <= 1'b0;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            counter   <= '0;
            ready     <= 1'b0;
            result    <= '0;
        end else begin
            ready <= (state == FIX) && enable;
            case (state)
                IDLE: begin
                    if (enable) begin
                        op        <= div_op;
                        sign_a    <= in_signed & rdata1[XLEN-1];
                        sign_b    <= in_signed & rdata2[XLEN-1];
                        spec_zero <= in_zero;
                        spec_ovf  <= in_ovf;
                        dvs       <= abs_b;
                        counter   <= CNT_LAST;
                        // Early-out and divide-by-zero both finish with quotient 0
                        // and remainder |dividend| before selection
                        if (in_zero || in_early) begin
                            quo <= '0;
                            rem <= {1'b0, abs_a};
                        end else begin
                            quo <= abs_a;
                            rem <= '0;
                        end
                    end
                end
                ITER: begin
                    if (enable) begin
                        quo     <= step_q;
                        rem     <= step_r;
                        counter <= counter - CW'(1);
                    end
                end
                FIX: begin
                    if (enable) begin
                        result <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_radix.sv
// tb/tb_div_unit_radix.sv - Self-checking bench for div_unit_radix (XLEN=32, BPC=1 and BPC=4)

module tb_div_unit_radix;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1;
    logic        en4;
    logic [1:0]  div_op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rdy1;
    logic        rdy4;
    logic [31:0] res1;
    logic [31:0] res4;

    always #5 clk = ~clk;

    div_unit_radix #(.XLEN(32), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .div_op(div_op),
        .rdata1(rdata1), .rdata2(rdata2), .ready(rdy1), .result(res1)
    );

    div_unit_radix #(.XLEN(32), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .div_op(div_op),
        .rdata1(rdata1), .rdata2(rdata2), .ready(rdy4), .result(res4)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res [2];

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] bb;
        aa = (!op[0] && a[31]) ? (32'd0 - a) : a;
        bb = (!op[0] && b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        if (EARLY_EN && aa < bb) return 2;
        return (sel != 0) ? 10 : 34;
    endfunction

    function automatic logic [31:0] rand_operand(input bit is_divisor);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: v = is_divisor ? 32'd0 : $urandom_range(0, 20);
            1: v = $urandom_range(1, 20);
            2: v = 32'hFFFF_FFFF;
            3: v = is_divisor ? (0 - $urandom_range(1, 20)) : 32'h8000_0000;
            4: v = v >> $urandom_range(0, 31);
            default: ;
        endcase
        return v;
    endfunction

    task automatic set_en(input int sel, input logic v);
        if (sel != 0) en4 = v; else en1 = v;
    endtask

    // kill_at != 0 drops enable in that cycle; keep leaves enable high after DONE
    task automatic run_op(input string name, input int sel, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int lat,
                          input int kill_at, input bit keep);
        int cyc;
        bit seen;
        logic r;
        @(posedge clk); #1;
        div_op = op;
        rdata1 = a;
        rdata2 = b;
        set_en(sel, 1'b1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                rdata1 = ~a;
                rdata2 = ~b;
            end
            r = (sel != 0) ? rdy4 : rdy1;
            if (r) seen = 1'b1;
            if (kill_at != 0 && cyc == kill_at) set_en(sel, 1'b0);
        end
        if (kill_at != 0) begin
            check({name, " no ready after kill"}, {31'd0, seen}, 32'd0);
            check({name, " result held"}, (sel != 0) ? res4 : res1, last_res[sel]);
        end else begin
            check({name, " latency"}, seen ? cyc : 32'hFFFF_FFFF, lat);
            check({name, " result"}, (sel != 0) ? res4 : res1, exp_r);
            last_res[sel] = exp_r;
            if (!keep) begin
                set_en(sel, 1'b0);
                @(posedge clk); #1;
                check({name, " ready one cycle"}, {31'd0, (sel != 0) ? rdy4 : rdy1}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit seen;

        tbl[0] = '{0, 2'b00, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 34};
        tbl[1] = '{0, 2'b10, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE, 34};
        tbl[2] = '{1, 2'b01, 32'hFFFF_FFFF, 32'h10,         32'h0FFF_FFFF, 10};
        tbl[3] = '{0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 2};
        tbl[4] = '{1, 2'b01, 32'd5,         32'd0,          32'hFFFF_FFFF, 2};
        tbl[5] = '{0, 2'b10, 32'd5,         32'd0,          32'd5,         2};
        tbl[6] = '{0, 2'b10, 32'd3,         32'd10,         32'd3,         EARLY_EN ? 2 : 34};

        rst    = 1'b1;
        en1    = 1'b0;
        en4    = 1'b0;
        div_op = 2'b00;
        rdata1 = '0;
        rdata2 = '0;
        last_res[0] = '0;
        last_res[1] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset ready", {30'd0, rdy4, rdy1}, 32'd0);
            check("reset result1", res1, 32'd0);
            check("reset result4", res4, 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].lat, 0, 1'b0);
        end

        // Back-to-back: enable stays high through DONE, next request in the following cycle
        run_op("b2b first", 1, 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 10, 0, 1'b1);
        run_op("b2b second", 1, 2'b11, 32'd100, 32'd7, 32'd2, 10, 0, 1'b0);

        // Kill mid-iteration, then a fresh full-latency request
        run_op("kill", 0, 2'b00, 32'd1000, 32'd7, 32'd0, 0, 10, 1'b0);
        run_op("after kill", 0, 2'b01, 32'd1000, 32'd7, 32'd142, 34, 0, 1'b0);

        // Reset mid-operation: no ready, result cleared
        @(posedge clk); #1;
        div_op = 2'b01; rdata1 = 32'd999; rdata2 = 32'd4; en1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; en1 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy1) seen = 1'b1;
        end
        check("reset mid-op ready", {31'd0, seen}, 32'd0);
        check("reset mid-op result", res1, 32'd0);
        last_res[0] = '0;
        last_res[1] = '0;

        // Randomised against the reference model
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = i % 2;
            op  = 2'($urandom_range(0, 3));
            a   = rand_operand(1'b0);
            b   = rand_operand(1'b1);
            run_op($sformatf("rand%0d op%0d %08h/%08h", i, op, a, b), sel, op, a, b,
                   model(op, a, b), exp_lat(sel, op, a, b), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
